// File: rtl/wspr_symbol_sequencer.sv
// wspr_symbol_sequencer: plays a host-loaded table of 2-bit WSPR symbols as
// 4-FSK tones by driving the CORDIC NCO frequency word and I-input amplitude.
// The NCO phase accumulator is never reset, so tone changes stay phase-continuous.
// Optional feature macro: WSPR_AMP_RAMP_EN (linear amplitude ramp at start/end).
module wspr_symbol_sequencer #(
   parameter int unsigned NUM_SYMBOLS = 162,
   parameter int unsigned SYM_CYCLES  = 52428800,
   parameter int unsigned TONE_STEP   = 82,
   parameter int unsigned AMP_FULL    = 19898,
   parameter int unsigned RAMP_SHIFT  = 10
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] base_freq,
   input  logic        sym_we,
   input  logic [7:0]  sym_addr,
   input  logic [1:0]  sym_data,
   input  logic        start,
   input  logic        abort,
   output logic        busy,
   output logic        done,
   output logic        tx_enable,
   output logic [7:0]  sym_index,
   output logic [31:0] frequency,
   output logic [15:0] amplitude
);

   localparam int unsigned AW = (NUM_SYMBOLS > 1) ? $clog2(NUM_SYMBOLS) : 1;
   localparam int unsigned CW = (SYM_CYCLES > 1) ? $clog2(SYM_CYCLES) : 1;
   localparam int unsigned RW = RAMP_SHIFT + 1;
   localparam int unsigned PW = 16 + RW;
   localparam logic [RW-1:0] RAMP_FULL = RW'(2 ** RAMP_SHIFT);
   localparam logic [CW-1:0] CNT_LAST  = CW'(SYM_CYCLES - 1);
   localparam logic [7:0]    LAST_IDX  = 8'(NUM_SYMBOLS - 1);

   typedef enum logic [1:0] {IDLE, RAMP_UP, SEND, RAMP_DOWN} state_t;

   state_t        state;
   logic [1:0]    mem [NUM_SYMBOLS];
   logic [31:0]   base_q;
   logic [CW-1:0] cnt;
   logic          wr_ok;
   logic [1:0]    sym0;
`ifdef WSPR_AMP_RAMP_EN
   logic [RW-1:0] ramp;
   logic          aborted;
`endif

   // Amplitude for ramp level r: (AMP_FULL * r) >> RAMP_SHIFT
   function automatic logic [15:0] ramp_amp(input logic [RW-1:0] r);
      logic [PW-1:0] prod;
      prod = PW'(AMP_FULL) * PW'(r);
      return 16'(prod >> RAMP_SHIFT);
   endfunction

   // Frequency word for a symbol, modulo 2**32
   function automatic logic [31:0] tone_freq(input logic [31:0] base, input logic [1:0] s);
      return base + 32'(s) * 32'(TONE_STEP);
   endfunction

   // Host writes are accepted only while idle and in range; a same-cycle write to
   // address 0 is forwarded so a start in that cycle sees the new symbol.
   always_comb begin
      wr_ok = sym_we && !busy && ({1'b0, sym_addr} < 9'(NUM_SYMBOLS));
      sym0  = (wr_ok && (sym_addr == 8'd0)) ? sym_data : mem[0];
   end

   // Symbol memory (not cleared by reset)
   always_ff @(posedge clock) begin
      if (wr_ok) mem[AW'(sym_addr)] <= sym_data;
   end

   // Transmission sequencer with registered outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         tx_enable <= 1'b0;
         sym_index <= 8'd0;
         frequency <= 32'd0;
         amplitude <= 16'd0;
         base_q    <= 32'd0;
         cnt       <= '0;
`ifdef WSPR_AMP_RAMP_EN
         ramp      <= '0;
         aborted   <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  base_q    <= base_freq;
                  busy      <= 1'b1;
                  tx_enable <= 1'b1;
                  sym_index <= 8'd0;
                  frequency <= tone_freq(base_freq, sym0);
                  cnt       <= '0;
`ifdef WSPR_AMP_RAMP_EN
                  state     <= RAMP_UP;
                  ramp      <= RW'(1);
                  amplitude <= ramp_amp(RW'(1));
                  aborted   <= 1'b0;
`else
                  state     <= SEND;
                  amplitude <= ramp_amp(RAMP_FULL);
`endif
               end
            end
`ifdef WSPR_AMP_RAMP_EN
            RAMP_UP: begin
               if (abort) begin
                  state     <= RAMP_DOWN;
                  aborted   <= 1'b1;
                  ramp      <= RW'(ramp - 1'b1);
                  amplitude <= ramp_amp(RW'(ramp - 1'b1));
               end else if (ramp == RAMP_FULL) begin
                  state <= SEND;
               end else begin
                  ramp      <= RW'(ramp + 1'b1);
                  amplitude <= ramp_amp(RW'(ramp + 1'b1));
               end
            end
`endif
            SEND: begin
               if (abort) begin
`ifdef WSPR_AMP_RAMP_EN
                  state     <= RAMP_DOWN;
                  aborted   <= 1'b1;
                  ramp      <= RW'(ramp - 1'b1);
                  amplitude <= ramp_amp(RW'(ramp - 1'b1));
`else
                  state     <= IDLE;
                  busy      <= 1'b0;
                  tx_enable <= 1'b0;
                  amplitude <= 16'd0;
`endif
               end else if (cnt == CNT_LAST) begin
                  cnt <= '0;
                  if (sym_index == LAST_IDX) begin
`ifdef WSPR_AMP_RAMP_EN
                     state     <= RAMP_DOWN;
                     ramp      <= RW'(ramp - 1'b1);
                     amplitude <= ramp_amp(RW'(ramp - 1'b1));
`else
                     state     <= IDLE;
                     busy      <= 1'b0;
                     tx_enable <= 1'b0;
                     amplitude <= 16'd0;
                     done      <= 1'b1;
`endif
                  end else begin
                     sym_index <= sym_index + 8'd1;
                     frequency <= tone_freq(base_q, mem[AW'(sym_index + 8'd1)]);
                  end
               end else begin
                  cnt <= CW'(cnt + 1'b1);
               end
            end
`ifdef WSPR_AMP_RAMP_EN
            RAMP_DOWN: begin
               if (ramp == '0) begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  tx_enable <= 1'b0;
                  done      <= !aborted;
               end else begin
                  ramp      <= RW'(ramp - 1'b1);
                  amplitude <= ramp_amp(RW'(ramp - 1'b1));
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wspr_symbol_sequencer.sv
// Bench for wspr_symbol_sequencer with NUM_SYMBOLS=4, SYM_CYCLES=3, TONE_STEP=82,
// RAMP_SHIFT=2. Expectations follow WSPR_AMP_RAMP_EN when it is defined.
module tb_wspr_symbol_sequencer;

   localparam int unsigned NS = 4;
   localparam int unsigned SC = 3;
   localparam int unsigned TS = 82;
   localparam int unsigned RS = 2;
`ifdef WSPR_AMP_RAMP_EN
   localparam int LEAD = 4;
`else
   localparam int LEAD = 0;
`endif
   localparam int SEND_LEN = NS * SC;
   localparam int BUSY_LEN = 2 * LEAD + SEND_LEN;

   logic        clock;
   logic        reset;
   logic [31:0] base_freq;
   logic        sym_we;
   logic [7:0]  sym_addr;
   logic [1:0]  sym_data;
   logic        start;
   logic        abort;
   logic        busy;
   logic        done;
   logic        tx_enable;
   logic [7:0]  sym_index;
   logic [31:0] frequency;
   logic [15:0] amplitude;

   wspr_symbol_sequencer #(
      .NUM_SYMBOLS(NS), .SYM_CYCLES(SC), .TONE_STEP(TS),
      .AMP_FULL(19898), .RAMP_SHIFT(RS)
   ) dut (
      .clock(clock), .reset(reset), .base_freq(base_freq),
      .sym_we(sym_we), .sym_addr(sym_addr), .sym_data(sym_data),
      .start(start), .abort(abort), .busy(busy), .done(done),
      .tx_enable(tx_enable), .sym_index(sym_index),
      .frequency(frequency), .amplitude(amplitude)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      string       name;
      logic        rst, st, ab, we;
      logic [7:0]  addr;
      logic [1:0]  data;
      logic [31:0] base;
      logic        e_busy, e_done;
      logic [7:0]  e_idx;
      logic [31:0] e_freq;
      logic [15:0] e_amp;
   } vec_t;

   vec_t vq[$];
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Ramp amplitude levels for r = 0..4 with AMP_FULL=19898, RAMP_SHIFT=2
   function automatic logic [15:0] lvl(input int k);
      case (k)
         1: return 16'd4974;
         2: return 16'd9949;
         3: return 16'd14923;
         4: return 16'd19898;
         default: return 16'd0;
      endcase
   endfunction

   task automatic add(input string nm, input logic rst, st, ab, we, input logic [7:0] addr,
                      input logic [1:0] data, input logic [31:0] base, input logic b, d,
                      input logic [7:0] idx, input logic [31:0] f, input logic [15:0] a);
      vec_t v;
      v.name = nm; v.rst = rst; v.st = st; v.ab = ab; v.we = we;
      v.addr = addr; v.data = data; v.base = base;
      v.e_busy = b; v.e_done = d; v.e_idx = idx; v.e_freq = f; v.e_amp = a;
      vq.push_back(v);
   endtask

   // Expected outputs at cycle c (c=1 is the cycle after start) of an unaborted run
   task automatic add_run(input string nm, input logic st, ab, we, input logic [7:0] addr,
                          input logic [1:0] data, input logic [31:0] base, input int c,
                          input logic [31:0] f0, f1, f2, f3);
      logic [31:0] f [4];
      int k;
      f[0] = f0; f[1] = f1; f[2] = f2; f[3] = f3;
      if (c <= LEAD) begin
         add(nm, 1'b0, st, ab, we, addr, data, base, 1'b1, 1'b0, 8'd0, f0, lvl(c));
      end else if (c <= LEAD + SEND_LEN) begin
         k = (c - LEAD - 1) / SC;
         add(nm, 1'b0, st, ab, we, addr, data, base, 1'b1, 1'b0, 8'(k), f[k], 16'd19898);
      end else if (c <= BUSY_LEN) begin
         add(nm, 1'b0, st, ab, we, addr, data, base, 1'b1, 1'b0, 8'd3, f3,
             lvl(LEAD + SEND_LEN + 4 - c));
      end else begin
         add(nm, 1'b0, st, ab, we, addr, data, base, 1'b0, (c == BUSY_LEN + 1), 8'd3, f3, 16'd0);
      end
   endtask

   initial begin
      int bc, dc, txe;
      reset = 1'b1; base_freq = '0; sym_we = 1'b0; sym_addr = '0;
      sym_data = '0; start = 1'b0; abort = 1'b0;

      // Reset state
      add("reset0", 1, 0, 0, 0, 8'd0, 2'd0, 0, 0, 0, 8'd0, 0, 0);
      add("reset1", 1, 0, 0, 0, 8'd0, 2'd0, 0, 0, 0, 8'd0, 0, 0);
      // Load {0,3,1,2}; out-of-range write must be dropped (would alias to addr 0)
      add("load0", 0, 0, 0, 1, 8'd0, 2'd0, 0, 0, 0, 8'd0, 0, 0);
      add("load1", 0, 0, 0, 1, 8'd1, 2'd3, 0, 0, 0, 8'd0, 0, 0);
      add("load2", 0, 0, 0, 1, 8'd2, 2'd1, 0, 0, 0, 8'd0, 0, 0);
      add("load3", 0, 0, 0, 1, 8'd3, 2'd2, 0, 0, 0, 8'd0, 0, 0);
      add("load200", 0, 0, 0, 1, 8'd200, 2'd3, 0, 0, 0, 8'd0, 0, 0);
      // Normal run; mid-run write to addr 2 and start pulse must both be ignored
      for (int c = 1; c <= BUSY_LEN + 2; c++)
         add_run("run1", (c == 1) || (c == 6), 1'b0, (c == 6), 8'd2, 2'd3,
                 (c == 6) ? 32'd5 : 32'd1000, c, 1000, 1246, 1082, 1164);
      // Abort on the first cycle of sym_index=1
      for (int c = 1; c <= LEAD + 4; c++)
         add_run("abort_pre", (c == 1), 1'b0, 1'b0, 8'd0, 2'd0, 32'd1000, c, 1000, 1246, 1082, 1164);
`ifdef WSPR_AMP_RAMP_EN
      for (int k = 0; k < 4; k++)
         add("abort_ramp", 0, 0, (k < 2), 0, 8'd0, 2'd0, 1000, 1, 0, 8'd1, 1246, lvl(3 - k));
`else
      add("abort_exit", 0, 0, 1, 0, 8'd0, 2'd0, 1000, 0, 0, 8'd1, 1246, 0);
`endif
      add("abort_idle0", 0, 0, 0, 0, 8'd0, 2'd0, 1000, 0, 0, 8'd1, 1246, 0);
      add("abort_idle1", 0, 0, 0, 0, 8'd0, 2'd0, 1000, 0, 0, 8'd1, 1246, 0);
      // Start+abort+write(addr0=3) together: write lands, start wins, 32-bit wrap
      for (int c = 1; c <= LEAD + 4; c++)
         add_run("wrap", (c == 1), (c == 1), (c == 1), 8'd0, 2'd3, 32'hFFFF_FFF0, c,
                 32'h0000_00E6, 32'h0000_00E6, 32'h0000_0042, 32'h0000_0094);
      // Reset mid-SEND
      add("mid_reset", 1, 0, 0, 0, 8'd0, 2'd0, 0, 0, 0, 8'd0, 0, 0);
      add("post_reset", 0, 0, 0, 0, 8'd0, 2'd0, 0, 0, 0, 8'd0, 0, 0);

      foreach (vq[i]) begin
         @(negedge clock);
         reset = vq[i].rst; start = vq[i].st; abort = vq[i].ab; sym_we = vq[i].we;
         sym_addr = vq[i].addr; sym_data = vq[i].data; base_freq = vq[i].base;
         @(posedge clock);
         #1;
         chk($sformatf("%s[%0d].busy", vq[i].name, i), 32'(busy), 32'(vq[i].e_busy));
         chk($sformatf("%s[%0d].tx_enable", vq[i].name, i), 32'(tx_enable), 32'(vq[i].e_busy));
         chk($sformatf("%s[%0d].done", vq[i].name, i), 32'(done), 32'(vq[i].e_done));
         chk($sformatf("%s[%0d].sym_index", vq[i].name, i), 32'(sym_index), 32'(vq[i].e_idx));
         chk($sformatf("%s[%0d].frequency", vq[i].name, i), frequency, vq[i].e_freq);
         chk($sformatf("%s[%0d].amplitude", vq[i].name, i), 32'(amplitude), 32'(vq[i].e_amp));
      end

      // Memory survives reset: run {3,3,1,2} from base 0, count busy/done over a fixed window
      @(negedge clock);
      reset = 1'b0; start = 1'b1; abort = 1'b0; sym_we = 1'b0; base_freq = 32'd0;
      @(posedge clock);
      #1;
      chk("retained_sym0_freq", frequency, 32'd246);
      bc = 0; dc = 0; txe = 0;
      for (int n = 0; n < BUSY_LEN + 6; n++) begin
         if (n > 0) begin
            @(posedge clock);
            #1;
         end
         if (n == 0) start = 1'b0;
         if (busy) bc++;
         if (done) dc++;
         if (tx_enable !== busy) txe++;
      end
      chk("busy_cycles", 32'(bc), 32'(BUSY_LEN));
      chk("done_pulses", 32'(dc), 32'd1);
      chk("tx_enable_tracks_busy", 32'(txe), 32'd0);
      chk("final_amplitude", 32'(amplitude), 32'd0);
      chk("final_frequency", frequency, 32'd164);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
